issue_bypass_scoreboard: RTL and testbench
==========================================

// Module: issue_bypass_scoreboard
// PURPOSE
//   N-lane issue gate and operand bypass network for the superscalar core.
//   Sits between the decode lanes and exec. Holds a pipeline of in-flight destination tags
//   (one slot per lane per stage), picks the youngest matching producer for every source
//   operand, and withholds lanes that hit a load-use or intra-bundle RAW hazard.
//   Keeps a saturating count of stall cycles.
// PARAMETERS
//   XLEN        32  data width
//   ISSUE_W     2   issue lanes; lane 0 is oldest in program order
//   NSTAGE      3   forwarding stages tracked (0=EX, 1=MEM, 2=WB)
//   LOAD_STAGE  1   first stage index at which a load result can be forwarded
//   REG_AW      5   register number width; register 0 is hard-wired zero
// PORTS
//   clk          in   1                    clock
//   rst          in   1                    synchronous reset, active-high
//   id_valid     in   ISSUE_W              lane holds a decoded instruction
//   id_src1      in   ISSUE_W*REG_AW       source-1 register number per lane
//   id_src2      in   ISSUE_W*REG_AW       source-2 register number per lane
//   id_dst       in   ISSUE_W*REG_AW       destination register number per lane
//   id_we        in   ISSUE_W              lane writes id_dst
//   id_is_load   in   ISSUE_W              lane is a load
//   rf_val1      in   ISSUE_W*XLEN         register-file value for src1 per lane
//   rf_val2      in   ISSUE_W*XLEN         register-file value for src2 per lane
//   fwd_data     in   NSTAGE*ISSUE_W*XLEN  result of stage s, slot l, at index s*ISSUE_W+l
//   flush        in   1                    branch taken in EX; squash the EX slots and the decode bundle
//   issue_mask   out  ISSUE_W              lanes issued this cycle (comb.)
//   opnd1        out  ISSUE_W*XLEN         resolved source-1 value per lane (comb.)
//   opnd2        out  ISSUE_W*XLEN         resolved source-2 value per lane (comb.)
//   stall_cnt    out  32                   cycles where issue_mask != id_valid; saturates
// BEHAVIOUR
// - Tag pipeline: slot[s][l] = {v, we, dst, is_load}. Advances every cycle with no backend stall:
//   - slot[0][l] <= issued lane l;
//   - slot[s][l] <= slot[s-1][l];
//   - the last stage drops out.
//   Non-issued lanes enter stage 0 with v=0.
// - A slot matches a source when: v && we && dst == src && src != 0.
// - Priority: lowest stage index wins. Within one stage, the highest lane index wins.
//   No match: use the rf value. Register 0 always yields 0.
// - Load-use: a source that matches a slot at stage < LOAD_STAGE with is_load=1 blocks its lane.
// - Intra-bundle RAW: lane j is blocked if any source equals id_dst of a valid, writing
//   lane i < j (dst != 0).
// - Issue is in order:
//   - issue_mask[j] = id_valid[j] and not blocked, and lane j-1 issued (or j = 0);
//   - the first blocked lane and every later lane are withheld;
//   - decode re-presents withheld lanes shifted down to lane 0 next cycle.
// - flush: issue_mask = 0, so nothing enters stage 0. All slot[0][*].v are cleared before they
//   advance, so the squashed producers never forward from MEM/WB. Older stages are untouched.
// - stall_cnt increments when id_valid != 0, issue_mask != id_valid, and flush = 0.
//   It holds at 0xFFFF_FFFF.
// - Reset: every slot v=0, stall_cnt=0. While rst=1, issue_mask=0.
//   Reset mid-operation discards all in-flight tags; after reset every operand reads rf.
// - Latency: operand select and issue_mask are combinational, same cycle.
//   A tag is visible at stage 0 the cycle after issue.
// STRUCTURE
// - Shared package/define file: stage indices (STG_EX, STG_MEM, STG_WB) and the slot field layout.
// - Sub-module opnd_select: one source operand.
//   - inputs: src, rf value, all slot tags, fwd_data;
//   - outputs: value, plus a load_block flag;
//   - instanced 2*ISSUE_W times.
// - Top level holds the tag registers, the intra-bundle comparator, issue-mask chain and stall counter.
// TESTING
// - EX fwd: cycle0 lane0 add x5 issues; cycle1 lane0 reads x5, fwd_data[EX,0]=0x1234
//   -> opnd1=0x1234, issue_mask=01.
// - Load-use: lw x6 issued; next cycle lane0 reads x6 -> issue_mask=00, stall_cnt=1.
//   Following cycle opnd1 = fwd_data[MEM,0].
// - Bundle RAW: lane0 writes x7, lane1 reads x7 -> issue_mask=01.
//   Next cycle lane0 (re-presented) takes fwd_data[EX,0].
// - Priority: x8 written by MEM slot and EX slot -> EX wins.
//   x8 written by EX lane0 and lane1 -> lane1 value.
// - Zero reg: producer writes x0, reader reads x0, rf_val=0 -> opnd=0, never forwarded.
// - Flush: EX writer x9 and MEM writer x9, flush=1; next cycle read x9 -> WB slot value
//   (older writer), issue_mask=0 during flush. rst mid-run -> slots cleared, opnd=rf value.

Source files
------------

// File: rtl/issue_bypass_scoreboard_pkg.sv
// Shared stage indices, default geometry and tag-slot bit layout for the
// issue/bypass scoreboard.
package issue_bypass_scoreboard_pkg;

  typedef enum logic [1:0] {
    STG_EX  = 2'd0,
    STG_MEM = 2'd1,
    STG_WB  = 2'd2
  } stage_e;

  localparam int unsigned DEF_XLEN       = 32;
  localparam int unsigned DEF_ISSUE_W    = 2;
  localparam int unsigned DEF_NSTAGE     = 3;
  localparam int unsigned DEF_LOAD_STAGE = 1;
  localparam int unsigned DEF_REG_AW     = 5;

  // Slot layout, MSB to LSB: {v, we, dst[aw-1:0], is_load}
  localparam int unsigned SLOT_LD  = 0;
  localparam int unsigned SLOT_DST = 1;

  function automatic int unsigned slot_we_bit(input int unsigned aw);
    return aw + 1;
  endfunction

  function automatic int unsigned slot_v_bit(input int unsigned aw);
    return aw + 2;
  endfunction

  function automatic int unsigned slot_width(input int unsigned aw);
    return aw + 3;
  endfunction

endpackage

// File: rtl/issue_bypass_scoreboard_opnd_select.sv
// Resolves one source operand against every in-flight tag slot: youngest
// matching producer wins, otherwise the register-file value; x0 reads zero.
module issue_bypass_scoreboard_opnd_select
  import issue_bypass_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned ISSUE_W    = DEF_ISSUE_W,
  parameter int unsigned NSTAGE     = DEF_NSTAGE,
  parameter int unsigned LOAD_STAGE = DEF_LOAD_STAGE,
  parameter int unsigned REG_AW     = DEF_REG_AW
) (
  input  logic [REG_AW-1:0]                                 src,
  input  logic [XLEN-1:0]                                   rf_val,
  input  logic [NSTAGE*ISSUE_W*slot_width(REG_AW)-1:0]      tags,
  input  logic [NSTAGE*ISSUE_W*XLEN-1:0]                    fwd_data,
  output logic [XLEN-1:0]                                   val,
  output logic                                              load_block
);

  localparam int unsigned SW   = slot_width(REG_AW);
  localparam int unsigned WE_B = slot_we_bit(REG_AW);
  localparam int unsigned V_B  = slot_v_bit(REG_AW);

  logic [SW-1:0] slot;

  always_comb begin
    val        = rf_val;
    load_block = 1'b0;
    slot       = '0;
    // Walk oldest producer first so the youngest match is the last to write val.
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      for (int unsigned l = 0; l < ISSUE_W; l++) begin
        slot = tags[((NSTAGE-1-k)*ISSUE_W + l)*SW +: SW];
        if (slot[V_B] && slot[WE_B] && (slot[SLOT_DST +: REG_AW] == src) && (src != '0)) begin
          val = fwd_data[((NSTAGE-1-k)*ISSUE_W + l)*XLEN +: XLEN];
          if (((NSTAGE-1-k) < LOAD_STAGE) && slot[SLOT_LD])
            load_block = 1'b1;
        end
      end
    end
    if (src == '0)
      val = '0;
  end

endmodule

// File: rtl/issue_bypass_scoreboard.sv
// N-lane in-order issue gate with operand bypass: tracks in-flight destination
// tags, forwards results, withholds load-use and intra-bundle RAW hazards.
module issue_bypass_scoreboard
  import issue_bypass_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned ISSUE_W    = DEF_ISSUE_W,
  parameter int unsigned NSTAGE     = DEF_NSTAGE,
  parameter int unsigned LOAD_STAGE = DEF_LOAD_STAGE,
  parameter int unsigned REG_AW     = DEF_REG_AW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ISSUE_W-1:0]               id_valid,
  input  logic [ISSUE_W*REG_AW-1:0]        id_src1,
  input  logic [ISSUE_W*REG_AW-1:0]        id_src2,
  input  logic [ISSUE_W*REG_AW-1:0]        id_dst,
  input  logic [ISSUE_W-1:0]               id_we,
  input  logic [ISSUE_W-1:0]               id_is_load,
  input  logic [ISSUE_W*XLEN-1:0]          rf_val1,
  input  logic [ISSUE_W*XLEN-1:0]          rf_val2,
  input  logic [NSTAGE*ISSUE_W*XLEN-1:0]   fwd_data,
  input  logic                             flush,
  output logic [ISSUE_W-1:0]               issue_mask,
  output logic [ISSUE_W*XLEN-1:0]          opnd1,
  output logic [ISSUE_W*XLEN-1:0]          opnd2,
  output logic [31:0]                      stall_cnt
);

  localparam int unsigned SW  = slot_width(REG_AW);
  localparam int unsigned TW  = NSTAGE*ISSUE_W*SW;
  localparam int unsigned V_B = slot_v_bit(REG_AW);

  logic [TW-1:0]      tags_q, tags_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;
  logic [ISSUE_W-1:0] blk1, blk2, raw_blk;
  logic               chain;

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
    issue_bypass_scoreboard_opnd_select #(
      .XLEN(XLEN), .ISSUE_W(ISSUE_W), .NSTAGE(NSTAGE),
      .LOAD_STAGE(LOAD_STAGE), .REG_AW(REG_AW)
    ) u_src1 (
      .src        (id_src1[g*REG_AW +: REG_AW]),
      .rf_val     (rf_val1[g*XLEN +: XLEN]),
      .tags       (tags_q),
      .fwd_data   (fwd_data),
      .val        (opnd1[g*XLEN +: XLEN]),
      .load_block (blk1[g])
    );
    issue_bypass_scoreboard_opnd_select #(
      .XLEN(XLEN), .ISSUE_W(ISSUE_W), .NSTAGE(NSTAGE),
      .LOAD_STAGE(LOAD_STAGE), .REG_AW(REG_AW)
    ) u_src2 (
      .src        (id_src2[g*REG_AW +: REG_AW]),
      .rf_val     (rf_val2[g*XLEN +: XLEN]),
      .tags       (tags_q),
      .fwd_data   (fwd_data),
      .val        (opnd2[g*XLEN +: XLEN]),
      .load_block (blk2[g])
    );
  end

  always_comb begin
    raw_blk = '0;
    for (int unsigned j = 1; j < ISSUE_W; j++) begin
      for (int unsigned i = 0; i < j; i++) begin
        if (id_valid[i] && id_we[i] && (id_dst[i*REG_AW +: REG_AW] != '0) &&
            ((id_src1[j*REG_AW +: REG_AW] == id_dst[i*REG_AW +: REG_AW]) ||
             (id_src2[j*REG_AW +: REG_AW] == id_dst[i*REG_AW +: REG_AW])))
          raw_blk[j] = 1'b1;
      end
    end
  end

  always_comb begin
    issue_mask = '0;
    chain      = !(rst || flush);
    for (int unsigned j = 0; j < ISSUE_W; j++) begin
      issue_mask[j] = chain && id_valid[j] && !(blk1[j] || blk2[j] || raw_blk[j]);
      chain         = issue_mask[j];
    end
  end

  always_comb begin
    tags_d = '0;
    for (int unsigned l = 0; l < ISSUE_W; l++)
      tags_d[l*SW +: SW] = {issue_mask[l], id_we[l], id_dst[l*REG_AW +: REG_AW], id_is_load[l]};
    for (int unsigned s = 1; s < NSTAGE; s++) begin
      for (int unsigned l = 0; l < ISSUE_W; l++) begin
        tags_d[(s*ISSUE_W + l)*SW +: SW] = tags_q[((s-1)*ISSUE_W + l)*SW +: SW];
        // A flush squashes the EX producers as they move into MEM.
        if (s == 1)
          tags_d[(s*ISSUE_W + l)*SW + V_B] = tags_q[l*SW + V_B] & ~flush;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((id_valid != '0) && (issue_mask != id_valid) && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tags_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      tags_q      <= tags_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_bypass_scoreboard.sv
// Randomized bench for issue_bypass_scoreboard against a program-order
// producer-list reference model.
module tb_issue_bypass_scoreboard;

  localparam int XLEN = 32;
  localparam int IW   = 2;
  localparam int NS   = 3;
  localparam int LS   = 1;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [IW-1:0]           id_valid, id_we, id_is_load;
  logic [IW*AW-1:0]        id_src1, id_src2, id_dst;
  logic [IW*XLEN-1:0]      rf_val1, rf_val2;
  logic [NS*IW*XLEN-1:0]   fwd_data;
  logic                    flush;
  logic [IW-1:0]           issue_mask;
  logic [IW*XLEN-1:0]      opnd1, opnd2;
  logic [31:0]             stall_cnt;

  issue_bypass_scoreboard #(
    .XLEN(XLEN), .ISSUE_W(IW), .NSTAGE(NS), .LOAD_STAGE(LS), .REG_AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_dst(id_dst), .id_we(id_we), .id_is_load(id_is_load), .rf_val1(rf_val1),
    .rf_val2(rf_val2), .fwd_data(fwd_data), .flush(flush), .issue_mask(issue_mask),
    .opnd1(opnd1), .opnd2(opnd2), .stall_cnt(stall_cnt)
  );

  // Per-lane stimulus
  int          v_s1[IW], v_s2[IW], v_dst[IW];
  bit          v_val[IW], v_we[IW], v_ld[IW];
  logic [XLEN-1:0] v_rf1[IW], v_rf2[IW], v_fwd[NS][IW];

  // Reference model: issued producers in program order, keyed by issue cycle and lane
  typedef struct {
    int cyc;
    int lane;
    int dst;
    bit we;
    bit ld;
    bit sq;
  } prod_t;

  prod_t       inflight[$];
  int          now = 0;
  logic [31:0] m_stall = '0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, now);
    end
  endtask

  function automatic void resolve(input int src, input logic [XLEN-1:0] rf,
                                  output logic [XLEN-1:0] val, output bit lb);
    int best = -1;
    int stg;
    val = rf;
    lb  = 1'b0;
    if (src == 0) begin
      val = '0;
      return;
    end
    foreach (inflight[i]) begin
      stg = now - inflight[i].cyc - 1;
      if (!inflight[i].sq && inflight[i].we && inflight[i].dst == src) begin
        if (stg < LS && inflight[i].ld) lb = 1'b1;
        if (inflight[i].cyc*IW + inflight[i].lane > best) begin
          best = inflight[i].cyc*IW + inflight[i].lane;
          val  = v_fwd[stg][inflight[i].lane];
        end
      end
    end
  endfunction

  task automatic lane(input int l, input bit v, input int s1, input int s2,
                      input int d, input bit we, input bit ld);
    v_val[l] = v; v_s1[l] = s1; v_s2[l] = s2; v_dst[l] = d; v_we[l] = we; v_ld[l] = ld;
  endtask

  task automatic idle();
    for (int l = 0; l < IW; l++) lane(l, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic step(input bit r, input bit fl);
    logic [IW-1:0]   exp_mask;
    logic [XLEN-1:0] e1, e2;
    bit              lb1, lb2, raw, chain;
    rst   = r;
    flush = fl;
    for (int l = 0; l < IW; l++) begin
      v_rf1[l] = $urandom;
      v_rf2[l] = $urandom;
      for (int s = 0; s < NS; s++) v_fwd[s][l] = $urandom;
      id_valid[l]   = v_val[l];
      id_we[l]      = v_we[l];
      id_is_load[l] = v_ld[l];
      id_src1[l*AW +: AW] = AW'(v_s1[l]);
      id_src2[l*AW +: AW] = AW'(v_s2[l]);
      id_dst[l*AW +: AW]  = AW'(v_dst[l]);
      rf_val1[l*XLEN +: XLEN] = v_rf1[l];
      rf_val2[l*XLEN +: XLEN] = v_rf2[l];
      for (int s = 0; s < NS; s++) fwd_data[(s*IW + l)*XLEN +: XLEN] = v_fwd[s][l];
    end
    #1;
    chain = !(r || fl);
    for (int j = 0; j < IW; j++) begin
      resolve(v_s1[j], v_rf1[j], e1, lb1);
      resolve(v_s2[j], v_rf2[j], e2, lb2);
      raw = 1'b0;
      for (int i = 0; i < j; i++)
        if (v_val[i] && v_we[i] && v_dst[i] != 0 && (v_s1[j] == v_dst[i] || v_s2[j] == v_dst[i]))
          raw = 1'b1;
      exp_mask[j] = chain && v_val[j] && !lb1 && !lb2 && !raw;
      chain       = exp_mask[j];
      chk($sformatf("opnd1[%0d]", j), opnd1[j*XLEN +: XLEN], e1);
      chk($sformatf("opnd2[%0d]", j), opnd2[j*XLEN +: XLEN], e2);
    end
    chk("issue_mask", 32'(issue_mask), 32'(exp_mask));
    @(posedge clk);
    if (r) begin
      inflight.delete();
      m_stall = '0;
    end else begin
      if (id_valid != '0 && exp_mask != id_valid && !fl && m_stall != '1) m_stall++;
      if (fl) foreach (inflight[i]) if (inflight[i].cyc == now - 1) inflight[i].sq = 1'b1;
      for (int l = 0; l < IW; l++)
        if (exp_mask[l])
          inflight.push_back('{cyc: now, lane: l, dst: v_dst[l], we: v_we[l], ld: v_ld[l], sq: 1'b0});
    end
    now++;
    while (inflight.size() > 0 && now - inflight[0].cyc - 1 >= NS) void'(inflight.pop_front());
    #1;
    chk("stall_cnt", stall_cnt, m_stall);
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1; flush = 1'b0;
    id_valid = '0; id_we = '0; id_is_load = '0;
    id_src1 = '0; id_src2 = '0; id_dst = '0;
    rf_val1 = '0; rf_val2 = '0; fwd_data = '0;
    @(negedge clk);
    lane(0, 1'b1, 3, 4, 5, 1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // EX forward
    idle(); lane(0, 1'b1, 1, 2, 5, 1'b1, 1'b0); step(1'b0, 1'b0);
    idle(); lane(0, 1'b1, 5, 0, 11, 1'b1, 1'b0); step(1'b0, 1'b0);
    // Load-use then MEM forward
    idle(); lane(0, 1'b1, 1, 2, 6, 1'b1, 1'b1); step(1'b0, 1'b0);
    idle(); lane(0, 1'b1, 6, 0, 12, 1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    // Intra-bundle RAW, re-presented lane takes EX forward
    idle(); lane(0, 1'b1, 1, 2, 7, 1'b1, 1'b0); lane(1, 1'b1, 7, 3, 13, 1'b1, 1'b0); step(1'b0, 1'b0);
    idle(); lane(0, 1'b1, 7, 3, 13, 1'b1, 1'b0); step(1'b0, 1'b0);
    // Priority: stage then lane
    idle(); lane(0, 1'b1, 1, 2, 8, 1'b1, 1'b0); step(1'b0, 1'b0);
    idle(); lane(0, 1'b1, 1, 2, 8, 1'b1, 1'b0); lane(1, 1'b1, 3, 4, 8, 1'b1, 1'b0); step(1'b0, 1'b0);
    idle(); lane(0, 1'b1, 8, 8, 14, 1'b1, 1'b0); step(1'b0, 1'b0);
    // Zero register
    idle(); lane(0, 1'b1, 1, 2, 0, 1'b1, 1'b0); step(1'b0, 1'b0);
    idle(); lane(0, 1'b1, 0, 0, 15, 1'b1, 1'b0); step(1'b0, 1'b0);
    // Flush squashes EX only
    idle(); lane(0, 1'b1, 1, 2, 9, 1'b1, 1'b0); step(1'b0, 1'b0);
    idle(); lane(0, 1'b1, 1, 2, 9, 1'b1, 1'b0); step(1'b0, 1'b0);
    idle(); lane(0, 1'b1, 9, 1, 16, 1'b1, 1'b0); step(1'b0, 1'b1);
    idle(); lane(0, 1'b1, 9, 1, 16, 1'b1, 1'b0); step(1'b0, 1'b0);
    // Reset mid-run
    idle(); lane(0, 1'b1, 1, 2, 10, 1'b1, 1'b0); step(1'b0, 1'b0);
    idle(); lane(0, 1'b1, 10, 1, 17, 1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < IW; l++)
        lane(l, $urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
